dmem_arbiter: RTL and testbench

Shares the single data-RAM port between the pipeline's MEM stage and an external word-wide requester (program loader / debug DMA). Sits between REG_EX_MEM outputs and RAM_B. Sequences one-cycle-latency reads and produces `cpu_stall`, which the hazard logic ORs into the stall of all pipeline registers. Bounded-starvation priority: the CPU wins ties until the external port has waited `EXT_MAX_WAIT` cycles.

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter: MEM stage vs external word requester.
// Bounded-starvation priority with one-cycle-latency read return.
module dmem_arbiter #(
  parameter int unsigned EXT_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_ubhw,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic [2:0]  ram_ubhw,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned CW =
    (EXT_MAX_WAIT > 0) ? $clog2(EXT_MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WMAX = CW'(EXT_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    EXT_RD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   cpu_rdata_q;
  logic [31:0]   ext_rdata_q;
  logic          cpu_win;
  logic          ext_win;
  logic          cpu_done;
  logic          cpu_ret;
  logic          ext_ret;

  // A read-return cycle under reset is dropped entirely.
  assign cpu_ret = (state == CPU_RD) && !rst;
  assign ext_ret = (state == EXT_RD) && !rst;

  always_comb begin
    state_nxt = state;
    cpu_win   = 1'b0;
    ext_win   = 1'b0;
    cpu_done  = 1'b0;
    ext_gnt   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_ubhw  = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (cpu_req && ext_req) begin
            ext_win = (wait_cnt == WMAX);
            cpu_win = !ext_win;
          end else begin
            cpu_win = cpu_req;
            ext_win = ext_req;
          end
          if (cpu_win) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
            ram_ubhw  = cpu_ubhw;
            cpu_done  = cpu_we;
            if (!cpu_we) state_nxt = CPU_RD;
          end else if (ext_win) begin
            ext_gnt   = 1'b1;
            ram_addr  = ext_addr & ~32'h3;
            ram_wdata = ext_wdata;
            ram_we    = ext_we;
            ram_ubhw  = 3'b010;
            if (!ext_we) state_nxt = EXT_RD;
          end
        end
        CPU_RD: begin
          cpu_done  = 1'b1;
          state_nxt = IDLE;
        end
        EXT_RD: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_done;
  assign ext_rvalid = ext_ret;
  assign cpu_rdata  = cpu_ret ? ram_rdata : cpu_rdata_q;
  assign ext_rdata  = ext_ret ? ram_rdata : ext_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (cpu_ret) cpu_rdata_q <= ram_rdata;
      if (ext_ret) ext_rdata_q <= ram_rdata;
      if (!ext_req || ext_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != WMAX)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with queue scoreboard.
// Monitor pops expected read data and RAM writes on each DUT event.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_ubhw;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic [2:0]  ram_ubhw;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  u;
  } wr_t;

  logic [31:0] cpu_q[$];
  logic [31:0] ext_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem [0:63];
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.EXT_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ubhw(cpu_ubhw), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_ubhw(ram_ubhw),
    .ram_rdata(ram_rdata)
  );

  // RAM model: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:2]];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    n_run++;
    n_fail++;
    $display("FAIL %s: DUT event with empty queue", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ext_rvalid) begin
        if (ext_q.size() == 0) unexp("ext_rvalid");
        else chk("ext_rdata", ext_rdata, ext_q.pop_front());
      end
      if (cpu_req && !cpu_we && !cpu_stall) begin
        if (cpu_q.size() == 0) unexp("cpu_load");
        else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (ram_we) begin
        if (wr_q.size() == 0) unexp("ram_we");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", ram_addr, w.a);
          chk("wr_data", ram_wdata, w.d);
          chk("wr_ubhw", 32'(ram_ubhw), 32'(w.u));
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
    mem[4]    = 32'hDEADBEEF;
    mem[16]   = 32'hCAFEF00D;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_ubhw  = 3'b010;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
    nxt();
    nxt();
    rst = 1'b0;
    smp();
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_ext_rdata", ext_rdata, 32'h0);
    chk("rst_ext_gnt", 32'(ext_gnt), 32'h0);
    chk("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    chk("rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);

    // lone CPU load
    nxt();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h10;
    cpu_q.push_back(32'hDEADBEEF);
    smp();
    chk("ld_addr", ram_addr, 32'h10);
    chk("ld_stall_n", 32'(cpu_stall), 32'h1);
    nxt();
    smp();
    chk("ld_stall_n1", 32'(cpu_stall), 32'h0);
    chk("ld_no_reissue", ram_addr, 32'h0);
    nxt();
    cpu_req = 1'b0;

    // lone CPU store
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h20;
    cpu_wdata = 32'h12345678;
    wr_q.push_back('{32'h20, 32'h12345678, 3'b010});
    smp();
    chk("st_stall", 32'(cpu_stall), 32'h0);
    chk("st_we", 32'(ram_we), 32'h1);
    nxt();
    cpu_req = 1'b0;
    smp();
    chk("st_we_off", 32'(ram_we), 32'h0);

    // ext read of an unaligned address
    nxt();
    ext_req  = 1'b1;
    ext_we   = 1'b0;
    ext_addr = 32'h43;
    ext_q.push_back(32'hCAFEF00D);
    smp();
    chk("ext_gnt", 32'(ext_gnt), 32'h1);
    chk("ext_addr", ram_addr, 32'h40);
    chk("ext_ubhw", 32'(ram_ubhw), 32'h2);
    nxt();
    ext_req = 1'b0;
    smp();
    chk("ext_rvalid", 32'(ext_rvalid), 32'h1);
    chk("ext_gnt_pulse", 32'(ext_gnt), 32'h0);
    nxt();
    smp();
    chk("ext_rvalid_off", 32'(ext_rvalid), 32'h0);
    chk("ext_rdata_hold", ext_rdata, 32'hCAFEF00D);

    // starvation bound: ext write vs back-to-back CPU stores
    nxt();
    ext_req   = 1'b1;
    ext_we    = 1'b1;
    ext_addr  = 32'h30;
    ext_wdata = 32'hA5A5A5A5;
    for (int k = 0; k < 5; k++) begin
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'(32'h24 + 4 * k);
      cpu_wdata = 32'(32'h100 + k);
      if (k < 4) wr_q.push_back('{cpu_addr, cpu_wdata, 3'b010});
      else wr_q.push_back('{32'h30, 32'hA5A5A5A5, 3'b010});
      smp();
      chk("sv_wait", 32'(dut.wait_cnt), 32'(k));
      chk("sv_gnt", 32'(ext_gnt), 32'(k == 4));
      chk("sv_stall", 32'(cpu_stall), 32'(k == 4));
      nxt();
    end
    ext_req = 1'b0;
    wr_q.push_back('{32'h34, 32'h104, 3'b010});
    smp();
    chk("sv_retry_stall", 32'(cpu_stall), 32'h0);
    chk("sv_wait_clr", 32'(dut.wait_cnt), 32'h0);
    nxt();
    cpu_req = 1'b0;

    // withdrawal after two contended cycles
    ext_req  = 1'b1;
    ext_we   = 1'b0;
    ext_addr = 32'h44;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) ext_req = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'(32'h50 + 4 * k);
      cpu_wdata = 32'(32'h200 + k);
      wr_q.push_back('{cpu_addr, cpu_wdata, 3'b010});
      smp();
      chk("wd_gnt", 32'(ext_gnt), 32'h0);
      chk("wd_addr", ram_addr, cpu_addr);
      chk("wd_wait", 32'(dut.wait_cnt), 32'(k));
      nxt();
    end
    cpu_req = 1'b0;
    smp();
    chk("wd_wait_clr", 32'(dut.wait_cnt), 32'h0);
    chk("wd_no_ram", 32'(ram_we), 32'h0);

    // reset while an ext read is returning
    nxt();
    ext_req  = 1'b1;
    ext_we   = 1'b0;
    ext_addr = 32'h40;
    smp();
    chk("rr_gnt", 32'(ext_gnt), 32'h1);
    nxt();
    ext_req = 1'b0;
    rst     = 1'b1;
    smp();
    chk("rr_rvalid", 32'(ext_rvalid), 32'h0);
    nxt();
    rst      = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h10;
    cpu_q.push_back(32'hDEADBEEF);
    smp();
    chk("rr_ext_rdata", ext_rdata, 32'h0);
    chk("rr_ld_addr", ram_addr, 32'h10);
    chk("rr_ld_stall", 32'(cpu_stall), 32'h1);
    nxt();
    ext_req  = 1'b1;
    ext_addr = 32'h10;
    ext_q.push_back(32'hDEADBEEF);
    smp();
    chk("rr_ld_done", 32'(cpu_stall), 32'h0);
    chk("cpurd_no_gnt", 32'(ext_gnt), 32'h0);
    nxt();
    cpu_req = 1'b0;
    smp();
    chk("idle_gnt", 32'(ext_gnt), 32'h1);
    nxt();
    ext_req = 1'b0;
    smp();
    nxt();
    nxt();
    chk("cpu_q_left", 32'(cpu_q.size()), 32'h0);
    chk("ext_q_left", 32'(ext_q.size()), 32'h0);
    chk("wr_q_left", 32'(wr_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
